// File: rtl/spi_master.sv
// Full-duplex SPI master: all four CPOL/CPHA modes, MSB/LSB-first order,
// MISO capture and one-hot active-low chip selects.
module spi_master #(
  parameter  int MAX_WIDTH = 32,
  parameter  int NUM_CS    = 4,
  parameter  int DIV_WIDTH = 16,
  localparam int DW        = $clog2(MAX_WIDTH),
  localparam int CSW       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [DIV_WIDTH-1:0] bit_period,
  input  logic [DW-1:0]        data_width,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic                 lsb_first,
  input  logic [CSW-1:0]       cs_sel,
  input  logic                 start,
  input  logic [MAX_WIDTH-1:0] tx_data,
  input  logic                 miso,
  output logic                 sck,
  output logic                 mosi,
  output logic [NUM_CS-1:0]    cs_n,
  output logic [MAX_WIDTH-1:0] rx_data,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_DATA, S_TRAIL} state_t;

  state_t               r_state, w_next;
  logic [DIV_WIDTH-1:0] r_bp, r_div;
  logic [DW:0]          r_half;
  logic [DW-1:0]        r_dw;
  logic                 r_cpha, r_lsb;
  logic [CSW-1:0]       r_cs;
  logic [MAX_WIDTH-1:0] r_tx, r_rx_sh, r_rx;
  logic                 r_sck, r_mosi, r_done;

  logic                 w_div_end, w_last_half, w_lead_edge, w_cs_active;
  logic [DW-1:0]        w_k;

  // Position in the word of the k-th bit on the wire.
  function automatic logic [DW-1:0] bit_pos(input logic lsb, input logic [DW-1:0] dw,
                                            input logic [DW-1:0] k);
    return lsb ? k : dw - k;
  endfunction

  assign w_div_end   = (r_div == r_bp);
  assign w_last_half = (r_half == {r_dw, 1'b1});
  assign w_lead_edge = ~r_half[0];
  assign w_k         = r_half[DW:1];
  assign w_cs_active = (r_state == S_LEAD) || (r_state == S_DATA);

  always_ff @(posedge clk) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LEAD;
      S_LEAD:  if (w_div_end) w_next = S_DATA;
      S_DATA:  if (w_div_end && w_last_half) w_next = S_TRAIL;
      S_TRAIL: if (w_div_end) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_bp    <= '0;
      r_div   <= '0;
      r_half  <= '0;
      r_dw    <= '0;
      r_cpha  <= 1'b0;
      r_lsb   <= 1'b0;
      r_cs    <= '0;
      r_tx    <= '0;
      r_rx_sh <= '0;
      r_rx    <= '0;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_sck  <= cpol;
          r_mosi <= 1'b0;
          r_div  <= '0;
          r_half <= '0;
          if (start) begin
            r_bp    <= bit_period;
            r_dw    <= data_width;
            r_cpha  <= cpha;
            r_lsb   <= lsb_first;
            r_cs    <= cs_sel;
            r_tx    <= tx_data;
            r_rx_sh <= '0;
            r_mosi  <= tx_data[bit_pos(lsb_first, data_width, '0)];
          end
        end
        S_LEAD: r_div <= w_div_end ? '0 : r_div + 1'b1;
        S_DATA: begin
          r_div <= w_div_end ? '0 : r_div + 1'b1;
          if (w_div_end) begin
            r_sck  <= ~r_sck;
            r_half <= r_half + 1'b1;
            // cpha selects which edge of each bit samples and which one shifts out
            if (w_lead_edge) begin
              if (!r_cpha) r_rx_sh[bit_pos(r_lsb, r_dw, w_k)] <= miso;
              else         r_mosi <= r_tx[bit_pos(r_lsb, r_dw, w_k)];
            end else begin
              if (r_cpha)             r_rx_sh[bit_pos(r_lsb, r_dw, w_k)] <= miso;
              else if (w_k != r_dw)   r_mosi <= r_tx[bit_pos(r_lsb, r_dw, w_k + 1'b1)];
            end
          end
        end
        S_TRAIL: begin
          r_div <= w_div_end ? '0 : r_div + 1'b1;
          if (w_div_end) begin
            r_done <= 1'b1;
            r_rx   <= r_rx_sh;
            r_mosi <= 1'b0;
          end
        end
        default: r_div <= '0;
      endcase
    end
  end

  // Out-of-range selects simply match no output.
  always_comb begin
    cs_n = '1;
    for (int i = 0; i < NUM_CS; i++)
      cs_n[i] = !(w_cs_active && (r_cs == CSW'(i)));
  end

  assign sck     = r_sck;
  assign mosi    = r_mosi;
  assign rx_data = r_rx;
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a per-cycle waveform model checks every
// output, plus literal expectations from hand-worked transfers.
module tb_spi_master;
  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [15:0] bit_period = '0;
  logic [4:0]  data_width = '0;
  logic        cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
  logic [1:0]  cs_sel = '0;
  logic [2:0]  cs_sel2 = '0;
  logic        start = 1'b0;
  logic [31:0] tx_data = '0;
  logic        loop_en = 1'b1, miso_val = 1'b0;
  logic        miso, sck, mosi, busy, done;
  logic [3:0]  cs_n;
  logic [31:0] rx_data;
  logic        miso2, sck2, mosi2, busy2, done2;
  logic [4:0]  cs_n2;
  logic [31:0] rx_data2;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  assign miso  = loop_en ? mosi : miso_val;
  assign miso2 = mosi2;

  spi_master #(.MAX_WIDTH(32), .NUM_CS(4), .DIV_WIDTH(16)) dut (
    .clk(clk), .nrst(nrst), .bit_period(bit_period), .data_width(data_width),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .cs_sel(cs_sel),
    .start(start), .tx_data(tx_data), .miso(miso), .sck(sck), .mosi(mosi),
    .cs_n(cs_n), .rx_data(rx_data), .busy(busy), .done(done));

  // Second instance whose 3-bit select can address a non-existent chip select.
  spi_master #(.MAX_WIDTH(32), .NUM_CS(5), .DIV_WIDTH(16)) dut2 (
    .clk(clk), .nrst(nrst), .bit_period(bit_period), .data_width(data_width),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .cs_sel(cs_sel2),
    .start(start), .tx_data(tx_data), .miso(miso2), .sck(sck2), .mosi(mosi2),
    .cs_n(cs_n2), .rx_data(rx_data2), .busy(busy2), .done(done2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_en = 1'b0, m_act = 1'b0;
  int          m_t = 0, mP = 1, mN = 1;
  logic        m_cpol = 1'b0, m_cpha = 1'b0, m_lsb = 1'b0, m_isck = 1'b0;
  logic [1:0]  m_cs = '0;
  logic [31:0] m_tx = '0, m_rx = '0, m_rxo = '0;

  function automatic logic mbit(input int k);
    return m_lsb ? m_tx[k] : m_tx[mN-1-k];
  endfunction

  always @(negedge clk) begin
    int   tend, h;
    logic es, em, dc;
    logic [3:0] ecs;
    if (m_en) begin
      tend = (2*mN + 2) * mP;
      if (m_act && m_t <= tend) begin
        if (m_t <= mP) begin
          es = m_cpol; em = mbit(0); ecs = ~(4'b1 << m_cs);
        end else if (m_t <= mP + 2*mN*mP) begin
          h   = (m_t - mP - 1) / mP;
          es  = m_cpol ^ h[0];
          em  = m_cpha ? mbit((h == 0) ? 0 : (h - 1) / 2) : mbit(h / 2);
          ecs = ~(4'b1 << m_cs);
        end else begin
          es = m_cpol; em = mbit(mN-1); ecs = 4'hF;
        end
        check("m_busy", busy, 1);
        check("m_done", done, 0);
        check("m_sck", sck, es);
        check("m_mosi", mosi, em);
        check("m_cs_n", cs_n, ecs);
        check("m_rx_hold", rx_data, m_rxo);
        for (int k = 0; k < mN; k++)
          if (m_t == (m_cpha ? (2*k + 3) : (2*k + 2)) * mP)
            m_rx[m_lsb ? k : mN-1-k] = miso;
      end else begin
        dc = m_act && (m_t == tend + 1);
        check("m_busy_idle", busy, 0);
        check("m_done_idle", done, dc);
        check("m_mosi_idle", mosi, 0);
        check("m_cs_n_idle", cs_n, 4'hF);
        if (dc) begin
          check("m_rx_done", rx_data, m_rx);
          check("m_sck_done", sck, m_cpol);
          m_rxo = m_rx;
        end else begin
          check("m_rx_idle", rx_data, m_rxo);
          check("m_sck_idle", sck, m_isck);
        end
      end
      if (!nrst) begin
        m_act = 1'b0; m_rxo = '0; m_isck = 1'b0;
      end else if ((!m_act || m_t == tend + 1) && start) begin
        m_act = 1'b1; m_t = 1; m_rx = '0;
        mP = int'(bit_period) + 1; mN = int'(data_width) + 1;
        m_cpol = cpol; m_cpha = cpha; m_lsb = lsb_first; m_cs = cs_sel; m_tx = tx_data;
      end else if (m_act && m_t <= tend) begin
        m_t++;
      end else begin
        m_act = 1'b0; m_isck = cpol;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic s_cpol, s_cpha, s_lsb;
  int   s_dw;

  task automatic setup(input int bp, input int dw, input logic pol, input logic pha,
                       input logic lsb, input logic [1:0] cs, input logic [31:0] tx);
    bit_period = 16'(bp); data_width = 5'(dw); cpol = pol; cpha = pha;
    lsb_first = lsb; cs_sel = cs; tx_data = tx;
    s_cpol = pol; s_cpha = pha; s_lsb = lsb; s_dw = dw;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic launch();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts cycles to done and records mosi on each sampling edge of sck.
  task automatic wait_done(input int bound, output int lat, output int nedg,
                           output logic [31:0] seq);
    logic prev, tgt;
    bit   to;
    int   k;
    prev = sck; tgt = (s_cpol == s_cpha); k = 0; seq = '0; nedg = 0; lat = 0; to = 1'b1;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      lat++;
      if (busy && sck !== prev && sck === tgt) begin
        if (k <= s_dw) seq[s_lsb ? k : s_dw - k] = mosi;
        k++; nedg++;
      end
      prev = sck;
      if (done) begin to = 1'b0; break; end
    end
    check("done_timeout", 32'(to), 0);
  endtask

  int          lat, ne, ndone, bad, tog;
  logic [31:0] seq;
  logic        prev2, seen2;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) begin @(posedge clk); #1; end
    m_en = 1'b1;
    check("rst_cs_n", cs_n, 4'hF);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_rx", rx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    nrst = 1'b1;

    // 1: mode 0, MSB first, 0xA5 loopback on cs 2
    loop_en = 1'b1;
    setup(1, 7, 1'b0, 1'b0, 1'b0, 2'd2, 32'hA5);
    launch();
    check("t1_cs_n", cs_n, 4'b1011);
    wait_done(200, lat, ne, seq);
    check("t1_latency", lat + 1, 37);
    check("t1_rx", rx_data, 32'hA5);
    check("t1_edges", ne, 8);
    check("t1_mosi_seq", seq, 32'hA5);

    // 2: mode 3, LSB first, miso tied high
    loop_en = 1'b0; miso_val = 1'b1;
    setup(1, 15, 1'b1, 1'b1, 1'b1, 2'd0, 32'h1234);
    check("t2_idle_sck", sck, 1);
    launch();
    wait_done(200, lat, ne, seq);
    check("t2_rx", rx_data, 32'h0000FFFF);
    check("t2_mosi_seq", seq, 32'h1234);
    check("t2_edges", ne, 16);

    // 3: single-bit transfers in modes 1 and 2 at clk/2
    loop_en = 1'b1;
    for (int m = 1; m <= 2; m++) begin
      setup(0, 0, (m == 2), (m == 1), 1'b0, 2'd1, 32'h1);
      launch();
      wait_done(50, lat, ne, seq);
      check("t3_latency", lat + 1, 5);
      check("t3_rx", rx_data, 1);
      check("t3_edges", ne, 1);
      check("t3_sample_bit", seq, 1);
    end

    // 4: 32-bit, start held then re-pulsed, start in done cycle
    setup(0, 31, 1'b0, 1'b0, 1'b0, 2'd3, 32'hDEADBEEF);
    start = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(200, lat, ne, seq);
    check("t4_latency", lat + 14, 67);
    check("t4_rx", rx_data, 32'hDEADBEEF);
    tx_data = 32'h0F1E2D3C;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t4_relaunch_busy", busy, 1);
    wait_done(200, lat, ne, seq);
    check("t4_latency2", lat + 1, 67);
    check("t4_rx2", rx_data, 32'h0F1E2D3C);
    check("t4_mosi_seq2", seq, 32'h0F1E2D3C);

    // 5: abort during bit 3, then a clean transfer
    setup(1, 7, 1'b0, 1'b0, 1'b0, 2'd0, 32'h3C);
    launch();
    repeat (14) begin @(posedge clk); #1; end
    nrst = 1'b0;
    @(posedge clk); #1;
    check("t5_cs_n", cs_n, 4'hF);
    check("t5_sck", sck, 0);
    check("t5_mosi", mosi, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    nrst = 1'b1;
    ndone = 0;
    repeat (40) begin @(posedge clk); #1; if (done) ndone++; end
    check("t5_no_done", ndone, 0);
    setup(1, 7, 1'b0, 1'b0, 1'b0, 2'd0, 32'h5A);
    launch();
    wait_done(200, lat, ne, seq);
    check("t5_latency", lat + 1, 37);
    check("t5_rx", rx_data, 32'h5A);

    // 6: out-of-range select on the five-output instance
    cs_sel2 = 3'd5;
    setup(0, 3, 1'b0, 1'b0, 1'b0, 2'd1, 32'h9);
    launch();
    bad = 0; tog = 0; seen2 = 1'b0; prev2 = sck2;
    for (int i = 0; i < 100; i++) begin
      if (cs_n2 !== 5'h1F) bad++;
      @(posedge clk); #1;
      if (sck2 !== prev2) tog++;
      prev2 = sck2;
      if (done2) begin seen2 = 1'b1; break; end
    end
    check("t6_cs_n2_never", bad, 0);
    check("t6_sck2_toggles", tog, 8);
    check("t6_done2", 32'(seen2), 1);
    check("t6_rx2", rx_data2, 32'h9);
    repeat (3) begin @(posedge clk); #1; end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
